// File: rtl/cart2600_pkg.sv
// rtl/cart2600_pkg.sv - shared 2600 cart mapper codes, sequencer state type and helpers
package cart2600_pkg;

    // Mapper selection codes shared with the 2600 cart mapper configuration.
    localparam logic [3:0] BS_NONE = 4'd0;
    localparam logic [3:0] BS_F8   = 4'd1;
    localparam logic [3:0] BS_F6   = 4'd2;
    localparam logic [3:0] BS_FE   = 4'd3;
    localparam logic [3:0] BS_E0   = 4'd4;
    localparam logic [3:0] BS_3F   = 4'd5;
    localparam logic [3:0] BS_F4   = 4'd6;
    localparam logic [3:0] BS_P2   = 4'd7;
    localparam logic [3:0] BS_FA   = 4'd8;
    localparam logic [3:0] BS_CV   = 4'd9;
    localparam logic [3:0] BS_UA   = 4'd11;
    localparam logic [3:0] BS_E7   = 4'd12;
    localparam logic [3:0] BS_F0   = 4'd13;
    localparam logic [3:0] BS_32   = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FEED,
        ST_SETTLE,
        ST_FINISH
    } cds_state_t;

    // Scan length saturates to the detector window instead of truncating the
    // 32-bit size, so a 32 KiB image scans 8192 bytes rather than 0.
    function automatic logic [13:0] sat_len(input logic [31:0] size, input int unsigned max_len);
        if (size > 32'(max_len)) begin
            return 14'(max_len);
        end
        return size[13:0];
    endfunction

endpackage

// File: rtl/cart_detect_seq.sv
// rtl/cart_detect_seq.sv - replays a downloaded cart image into the bankswitch detector
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   start, cart_size, ext_bs  scan trigger, image size, extension-forced mapper
//   mem_req/mem_addr          cart memory read request (held until mem_ack)
//   mem_ack/mem_data          read completion with same-cycle data
//   det_addr/det_data         byte presented to the detector
//   det_enable                one-cycle detector byte strobe
//   det_force_bs, det_sc      detector results sampled at the end of the scan
//   busy, done                scan in progress / results latched pulse
//   bs_sel, sc_sel, err       latched mapper, Superchip flag, ack-timeout flag
module cart_detect_seq
    import cart2600_pkg::*;
#(
    parameter int SCAN_MAX    = 8192,
    parameter int SETTLE      = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] cart_size,
    input  logic [3:0]  ext_bs,
    output logic        mem_req,
    output logic [12:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [12:0] det_addr,
    output logic [7:0]  det_data,
    output logic        det_enable,
    input  logic [3:0]  det_force_bs,
    input  logic        det_sc,
    output logic        busy,
    output logic        done,
    output logic [3:0]  bs_sel,
    output logic        sc_sel,
    output logic        err
);

    localparam int SETTLE_N = (SETTLE < 1) ? 1 : SETTLE;
    localparam int TO_N     = (ACK_TIMEOUT < 1) ? 1 : ACK_TIMEOUT;
    localparam int TW       = $clog2(TO_N + 1);
    localparam int SW       = $clog2(SETTLE_N + 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TO_N - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_N - 1);

    cds_state_t    state;
    cds_state_t    state_nx;
    logic [13:0]   len;
    logic [13:0]   addr;
    logic [3:0]    ext_q;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt;
    logic          last_byte;
    logic          timeout;

    // 14-bit compare so len == 8192 ends at 0x1FFF without wrapping to 0.
    assign last_byte = (addr == (len - 14'd1));
    assign timeout   = (tcnt == TO_LAST);
    assign mem_addr  = addr[12:0];

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        det_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (sat_len(cart_size, SCAN_MAX) == 14'd0) ? ST_SETTLE : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nx = ST_FEED;
                end else if (timeout) begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_FEED: begin
                det_enable = 1'b1;
                state_nx   = last_byte ? ST_SETTLE : ST_REQ;
            end
            ST_SETTLE: begin
                if (scnt == SETTLE_LAST) begin
                    state_nx = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            len      <= '0;
            addr     <= '0;
            ext_q    <= '0;
            tcnt     <= '0;
            scnt     <= '0;
            det_addr <= '0;
            det_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bs_sel   <= '0;
            sc_sel   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            // busy covers the done cycle; a start in that same cycle re-arms it below.
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len   <= sat_len(cart_size, SCAN_MAX);
                        ext_q <= ext_bs;
                        addr  <= '0;
                        err   <= 1'b0;
                        tcnt  <= '0;
                        scnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        det_data <= mem_data;
                        det_addr <= addr[12:0];
                        tcnt     <= '0;
                    end else if (timeout) begin
                        err  <= 1'b1;
                        tcnt <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_FEED: begin
                    if (!last_byte) begin
                        addr <= addr + 14'd1;
                    end
                end
                ST_SETTLE: begin
                    scnt <= (scnt == SETTLE_LAST) ? '0 : scnt + SW'(1);
                end
                ST_FINISH: begin
                    // Extension mapper wins even after an aborted scan; detector
                    // results are not trusted when the scan did not complete.
                    bs_sel <= (ext_q != 4'd0) ? ext_q : (err ? 4'd0 : det_force_bs);
                    sc_sel <= err ? 1'b0 : det_sc;
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_detect_seq.sv
// tb/tb_cart_detect_seq.sv - scoreboard bench for cart_detect_seq
module tb_cart_detect_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] cart_size;
    logic [3:0]  ext_bs;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [12:0] det_addr;
    logic [7:0]  det_data;
    logic        det_enable;
    logic [3:0]  det_force_bs;
    logic        det_sc;
    logic        busy;
    logic        done;
    logic [3:0]  bs_sel;
    logic        sc_sel;
    logic        err;

    always #5 clk = ~clk;

    cart_detect_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cart_size(cart_size), .ext_bs(ext_bs),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .det_addr(det_addr), .det_data(det_data), .det_enable(det_enable),
        .det_force_bs(det_force_bs), .det_sc(det_sc), .busy(busy), .done(done),
        .bs_sel(bs_sel), .sc_sel(sc_sel), .err(err)
    );

    typedef struct {
        int         lat;
        logic [3:0] bs;
        logic       sc;
        logic       er;
        int         pulses;
        bit         noreq;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] img [0:8191];
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         scan_id = 0;
    int         waits = 0;
    logic       ack_en = 1'b1;
    logic       force_ack = 1'b0;
    int         wcnt = 0;

    // Memory model: ack after `waits` stalled REQ cycles, data valid with ack.
    always_comb begin
        mem_ack  = force_ack | (ack_en & mem_req & (wcnt >= waits));
        mem_data = img[mem_addr];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: address/data sequence of detector feed and scoreboard on done.
    int          seen_id = 0;
    int          exp_addr = 0;
    int          pulses = 0;
    int          reqs = 0;
    logic        prev_req = 1'b0;
    logic        prev_en = 1'b0;
    logic [12:0] prev_addr = '0;
    exp_t        e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_req = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (scan_id != seen_id) begin
                seen_id  = scan_id;
                exp_addr = 0;
                pulses   = 0;
                reqs     = 0;
            end
            if (mem_req) reqs++;
            if (prev_req && mem_req) check("mem_addr_stable", 64'(mem_addr), 64'(prev_addr));
            if (det_enable) begin
                check("det_enable_gap", 64'(prev_en), 64'(0));
                check("det_addr", 64'(det_addr), 64'(exp_addr));
                check("det_data", 64'(det_data), 64'(img[exp_addr[12:0]]));
                exp_addr++;
                pulses++;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    check("done_latency", 64'(cyc - start_cyc), 64'(e.lat));
                    check("bs_sel", 64'(bs_sel), 64'(e.bs));
                    check("sc_sel", 64'(sc_sel), 64'(e.sc));
                    check("err", 64'(err), 64'(e.er));
                    check("pulse_count", 64'(pulses), 64'(e.pulses));
                    if (e.noreq) check("no_mem_req", 64'(reqs), 64'(0));
                end
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
            prev_en   = det_enable;
        end
    end

    task automatic issue(input logic [31:0] size, input logic [3:0] eb, input logic [3:0] dbs,
                         input logic dsc, input int w, input exp_t ex);
        cart_size    = size;
        ext_bs       = eb;
        det_force_bs = dbs;
        det_sc       = dsc;
        waits        = w;
        start        = 1'b1;
        start_cyc    = cyc;
        scan_id      = scan_id + 1;
        sbq.push_back(ex);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = 0;
        while (sbq.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (sbq.size() != 0) begin
            check("done_timeout", 64'(0), 64'(1));
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"},
              64'({mem_req, mem_addr, det_addr, det_data, det_enable, busy, done, bs_sel, sc_sel, err}),
              64'(0));
    endtask

    initial begin
        int b;
        for (int i = 0; i < 8192; i++) img[i] = 8'(i) ^ 8'h5A;
        img[256]  = 8'h85; img[257]  = 8'h3F;
        img[1024] = 8'h85; img[1025] = 8'h3F;
        img[2000] = 8'h9D; img[2001] = 8'hFF; img[2002] = 8'hF3;

        reset_n = 1'b0; start = 1'b0; cart_size = '0; ext_bs = '0;
        det_force_bs = '0; det_sc = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // 3F image, zero-wait memory: 2*4096+3+2 cycles.
        issue(32'd4096, 4'd0, 4'd5, 1'b0, 0, '{8197, 4'd5, 1'b0, 1'b0, 4096, 1'b0});
        wait_done(9000);

        // Oversized image with 3 wait states: saturates to 8192 bytes, 5 cycles/byte.
        issue(32'd32768, 4'd0, 4'd1, 1'b1, 3, '{40965, 4'd1, 1'b1, 1'b0, 8192, 1'b0});
        wait_done(42000);

        // Extension mapper overrides the detector's CV result.
        issue(32'd2048, 4'd2, 4'd9, 1'b0, 0, '{4101, 4'd2, 1'b0, 1'b0, 2048, 1'b0});
        wait_done(5000);

        // Empty image: straight to settle, no memory traffic.
        issue(32'd0, 4'd6, 4'd3, 1'b0, 0, '{5, 4'd6, 1'b0, 1'b0, 0, 1'b1});
        wait_done(100);

        // Memory never acks: 255 REQ cycles then abort.
        ack_en = 1'b0;
        issue(32'd100, 4'd0, 4'd7, 1'b1, 0, '{260, 4'd0, 1'b0, 1'b1, 0, 1'b0});
        wait_done(400);
        repeat (3) @(negedge clk);
        check("err_held", 64'(err), 64'(1));
        ack_en = 1'b1;

        // Single-byte image clears err from the aborted scan.
        issue(32'd1, 4'd0, 4'd4, 1'b0, 0, '{7, 4'd4, 1'b0, 1'b0, 1, 1'b0});
        wait_done(100);

        // Reset while address 100 is being fed.
        issue(32'd300, 4'd0, 4'd1, 1'b0, 0, '{605, 4'd1, 1'b0, 1'b0, 300, 1'b0});
        b = 0;
        while (!(det_enable && det_addr == 13'd100) && b < 1000) begin
            @(negedge clk);
            b++;
        end
        check("reach_addr_100", 64'(det_addr), 64'(100));
        reset_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_all_zero("midscan_reset");
        reset_n   = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        check("stray_ack_ignored", 64'({busy, mem_req, det_enable, det_data}), 64'(0));

        // Fresh scan restarts at 0; a second start mid-scan is ignored.
        issue(32'd200, 4'd0, 4'd1, 1'b0, 0, '{405, 4'd1, 1'b0, 1'b0, 200, 1'b0});
        repeat (50) @(negedge clk);
        check("busy_midscan", 64'(busy), 64'(1));
        cart_size = 32'd10;
        ext_bs    = 4'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(500);
        repeat (20) @(negedge clk);
        check("busy_after_done", 64'(busy), 64'(0));
        check("bs_sel_held", 64'(bs_sel), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
